// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin sharing of one combinational ALU between two
// issue requesters, with a single valid/ready output register toward writeback.
`default_nettype none

module alu_issue_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             resetn,

  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [13:0]      r0_op,
  input  logic [31:0]      r0_src1,
  input  logic [31:0]      r0_src2,
  input  logic [TAG_W-1:0] r0_tag,

  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [13:0]      r1_op,
  input  logic [31:0]      r1_src1,
  input  logic [31:0]      r1_src2,
  input  logic [TAG_W-1:0] r1_tag,

  output logic [13:0]      alu_op,
  output logic [31:0]      alu_src1,
  output logic [31:0]      alu_src2,
  input  logic [31:0]      alu_result,

  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_src,
  output logic             res_err
);

  localparam int OP_W = 14;

  logic             rr;
  logic             can_issue;
  logic             grant_valid;
  logic             grant_id;
  logic [OP_W-1:0]  sel_op;
  logic [31:0]      sel_src1;
  logic [31:0]      sel_src2;
  logic [TAG_W-1:0] sel_tag;
  logic             op_legal;

  // The output register can accept a new result when empty or being drained now.
  assign can_issue = ~res_valid | res_ready;

  always_comb begin
    grant_id = 1'b0;
    if (r0_valid && r1_valid) begin
      grant_id = rr;
    end else if (r1_valid) begin
      grant_id = 1'b1;
    end
    grant_valid = (r0_valid | r1_valid) & can_issue;
  end

  assign r0_ready = grant_valid & ~grant_id;
  assign r1_ready = grant_valid &  grant_id;

  always_comb begin
    sel_op   = r0_op;
    sel_src1 = r0_src1;
    sel_src2 = r0_src2;
    sel_tag  = r0_tag;
    if (grant_id) begin
      sel_op   = r1_op;
      sel_src1 = r1_src1;
      sel_src2 = r1_src2;
      sel_tag  = r1_tag;
    end
  end

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign op_legal = (sel_op != '0) && ((sel_op & (sel_op - 14'd1)) == '0);

  always_comb begin
    alu_op   = '0;
    alu_src1 = '0;
    alu_src2 = '0;
    if (grant_valid) begin
      alu_src1 = sel_src1;
      alu_src2 = sel_src2;
      if (op_legal) begin
        alu_op = sel_op;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr        <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
      res_src   <= 1'b0;
      res_err   <= 1'b0;
    end else if (grant_valid) begin
      rr        <= ~grant_id;
      res_valid <= 1'b1;
      res_data  <= alu_result;
      res_tag   <= sel_tag;
      res_src   <= grant_id;
      res_err   <= ~op_legal;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Shares one `alu_openla500`-style combinational ALU between two issue requesters. Arbitration is round-robin, and each requester has its own valid/ready handshake. The block drives the ALU's op and operand inputs from the granted request and checks that the op is one-hot. It captures the result, tag and requester id in a single output register that is drained by a valid/ready consumer, sustaining one operation per cycle when the consumer never stalls. It sits between the issue stage and writeback when two pipes must share one integer ALU.

## Interface
- `TAG_W`, default 4: width of the opaque tag carried from request to result.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `resetn` input, 1 bit: asynchronous, active-low reset.
- `r0_valid` input, 1 bit: requester 0 has an operation.
- `r0_ready` output, 1 bit: requester 0 is granted this cycle.
- `r0_op` input, 14 bits: one-hot ALU op in the bit order add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui, andn, orn.
- `r0_src1`, `r0_src2` inputs, 32 bits each: operands.
- `r0_tag` input, `TAG_W` bits: tag.
- `r1_valid`, `r1_ready`, `r1_op`, `r1_src1`, `r1_src2`, `r1_tag`: same as the r0 ports, for requester 1.
- `alu_op` output, 14 bits: op driven to the shared ALU.
- `alu_src1`, `alu_src2` outputs, 32 bits each: operands driven to the shared ALU.
- `alu_result` input, 32 bits: the shared ALU's combinational result.
- `res_valid` output, 1 bit: the output register holds a result.
- `res_ready` input, 1 bit: the consumer accepts the result.
- `res_data` output, 32 bits: result value.
- `res_tag` output, `TAG_W` bits: tag of the operation that produced the result.
- `res_src` output, 1 bit: requester id (0 or 1).
- `res_err` output, 1 bit: the op was not one-hot.

## Operation
- `can_issue = ~res_valid | res_ready`.
- Round-robin pointer `rr` (1 bit) names the preferred requester.
- Grant rules:
  - Both valid: the requester equal to `rr` is granted.
  - Only one valid: that requester is granted, regardless of `rr`.
  - No grant when `can_issue` is 0.
- `rN_ready = can_issue & grant_N`.
  - At most one of `r0_ready`/`r1_ready` is high in any cycle.
  - Ready is combinational from the valids, `rr`, `res_valid` and `res_ready`.
- Pointer update: on every accepted issue, `rr <= ~granted_id`. With no issue, `rr` holds.
- ALU drive while a grant is active:
  - `alu_src1`/`alu_src2` take the granted operands.
  - `alu_op` takes the granted op if that op has exactly one bit set; otherwise `alu_op` = 0.
- ALU drive with no grant: `alu_op`, `alu_src1` and `alu_src2` are all 0.
- Capture on issue (valid & ready), into the output register:
  - `res_data <= alu_result`. This is 0 for an illegal op, because the ALU is fed op 0.
  - `res_tag <=` the granted tag; `res_src <=` the granted id.
  - `res_err <= ~onehot(op)`. An op of zero bits and an op of two or more bits are both illegal.
  - `res_valid <= 1`.
- Drain with no new issue: when `res_valid & res_ready` and nothing is issued, `res_valid <= 0`; the data fields hold their last values.
- Stall: while `res_valid & ~res_ready`, every `res_*` output is held stable and both readys are 0.
- Requesters may drop valid without a handshake. The arbiter has no memory of unaccepted requests.

## Timing
- Reset values (asynchronous, on `resetn` low):
  - `res_valid`=0, `res_data`=0, `res_tag`=0, `res_src`=0, `res_err`=0.
  - `rr`=0, so requester 0 is preferred first.
- Reset mid-operation discards any held result, even if it was not yet drained.
- The first grant is possible in the first clock edge after `resetn` deasserts.
- Latency: a request accepted at edge N has its result on `res_*` with `res_valid`=1 after edge N, i.e. in cycle N+1.
- Throughput: 1 result per cycle while `res_ready` stays 1.
- Simultaneous drain and issue in the same cycle: the register is overwritten with the new result and `res_valid` stays 1. There is no bubble.
- Fairness: with both requesters continuously valid and no stalls, grants alternate 0,1,0,1. A waiting requester is granted within 2 issue slots.
- A stall of K cycles delays both requesters by exactly K cycles. The stall does not change `rr`.

## Test plan
- Reset, then single requester:
  - Stimulus: `resetn` low for 3 cycles, then high. r0 issues add 5+7 with tag 3; r1 idle; `res_ready`=1.
  - Required response: `r0_ready`=1; in the next cycle `res_valid`=1, `res_data`=12, `res_tag`=3, `res_src`=0, `res_err`=0.
- Contention:
  - Stimulus: both requesters valid for 6 cycles with `res_ready`=1. r0 issues sub 10-3 (tag 1); r1 issues sll 1<<4 (tag 2).
  - Required response: grants go 0,1,0,1,0,1; results alternate 7/`res_src` 0 and 16/`res_src` 1; a result appears every cycle.
- Backpressure:
  - Stimulus: `res_ready`=0 for 4 cycles while a result is held and both requesters are valid.
  - Required response: both readys are 0 and all `res_*` outputs are frozen.
  - Then raise `res_ready`: in that same cycle the next grant goes to the requester named by `rr`, and the new result appears the following cycle.
- Illegal op:
  - Stimulus: r1 issues op 14'h0003 with tag 5, then op 14'h0000 with tag 6.
  - Required response: each result has `res_err`=1 and `res_data`=0; `alu_op` is 0 during each grant; arbitration continues normally.
- Asynchronous reset mid-stream:
  - Stimulus: assert `resetn` low mid-cycle while `res_valid`=1 and `rr`=1.
  - Required response: `res_valid`, `res_data`, `res_tag`, `res_src` and `res_err` all go to 0 immediately, without waiting for a clock edge. After release, the first contended grant goes to requester 0.
- Idle drive:
  - Stimulus: no requesters valid.
  - Required response: `alu_op`, `alu_src1` and `alu_src2` are all 0; a held result drains on `res_ready`, after which `res_valid`=0.
